// File: rtl/pcw_mem_pkg.sv
// Shared types for the PCW video/system RAM arbiter: owner tags and the
// per-operation entry carried down the read-return pipeline.
package pcw_mem_pkg;

    localparam int PCW_AW = 17;
    localparam int PCW_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   we;
    } tag_entry_t;

    localparam tag_entry_t TAG_IDLE = '{owner: OWN_NONE, we: 1'b0};

    function automatic tag_entry_t make_tag(input owner_t owner, input logic we);
        tag_entry_t t;
        t.owner = owner;
        t.we    = we;
        return t;
    endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register that delays each issued op's owner tag so it
// emerges in the cycle the RAM returns that op's read data.
module mem_tag_pipe
    import pcw_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  tag_entry_t tag_in,
    output tag_entry_t tag_out
);

    tag_entry_t stage_r [DEPTH];

    // Shift one stage per clock; clearing drops every in-flight tag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= TAG_IDLE;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/pcw_mem_arbiter.sv
// Single-port RAM arbiter: video owns ce_pix slots, CPU and DMA share the
// remaining cycles round-robin; one registered RAM op per clk_sys.
module pcw_mem_arbiter
    import pcw_mem_pkg::*;
#(
    parameter int AW      = PCW_AW,
    parameter int DW      = PCW_DW,
    parameter int MEM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0]    rst_sync_r;
    logic          rst_n_s;
    logic          cpu_busy_r, dma_busy_r;
    owner_t        rr_owner_r;
    logic          cpu_elig_s, dma_elig_s, both_elig_s, vid_slot_s;
    owner_t        grant_s;
    logic          issue_we_s;
    logic [AW-1:0] issue_addr_s;
    logic [DW-1:0] issue_wdata_s;
    logic          mem_en_r, mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          cpu_ack_r, dma_ack_r;
    logic [DW-1:0] cpu_rdata_r, dma_rdata_r, vid_hold_r;
    tag_entry_t    tail_s;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Slot decision: video wins its ce_pix slot, otherwise CPU/DMA by eligibility and pointer.
    always_comb begin
        vid_slot_s  = ce_pix & vid_req;
        cpu_elig_s  = cpu_req & ~cpu_busy_r;
        dma_elig_s  = dma_req & ~dma_busy_r;
        both_elig_s = cpu_elig_s & dma_elig_s;
        grant_s     = OWN_NONE;
        if (vid_slot_s) begin
            grant_s = OWN_VID;
        end else if (both_elig_s) begin
            grant_s = (rr_owner_r == OWN_DMA) ? OWN_DMA : OWN_CPU;
        end else if (cpu_elig_s) begin
            grant_s = OWN_CPU;
        end else if (dma_elig_s) begin
            grant_s = OWN_DMA;
        end else begin
            grant_s = OWN_NONE;
        end
    end

    // Operation fields for the granted requester; idle slots keep the bus stable.
    always_comb begin
        issue_we_s    = mem_we_r;
        issue_addr_s  = mem_addr_r;
        issue_wdata_s = mem_wdata_r;
        case (grant_s)
            OWN_VID: begin
                issue_we_s    = 1'b0;
                issue_addr_s  = vid_addr;
                issue_wdata_s = mem_wdata_r;
            end
            OWN_CPU: begin
                issue_we_s    = cpu_we;
                issue_addr_s  = cpu_addr;
                issue_wdata_s = cpu_wdata;
            end
            OWN_DMA: begin
                issue_we_s    = dma_we;
                issue_addr_s  = dma_addr;
                issue_wdata_s = dma_wdata;
            end
            default: begin
                issue_we_s    = mem_we_r;
                issue_addr_s  = mem_addr_r;
                issue_wdata_s = mem_wdata_r;
            end
        endcase
    end

    mem_tag_pipe #(
        .DEPTH (MEM_LAT + 1)
    ) u_tag_pipe (
        .clk_sys (clk_sys),
        .reset_n (rst_n_s),
        .tag_in  (make_tag(grant_s, issue_we_s)),
        .tag_out (tail_s)
    );

    // Register the issued op onto the RAM port and track fairness/busy state.
    always_ff @(posedge clk_sys or negedge rst_n_s) begin
        if (!rst_n_s) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rr_owner_r  <= OWN_CPU;
            cpu_busy_r  <= 1'b0;
            dma_busy_r  <= 1'b0;
        end else begin
            mem_en_r <= (grant_s != OWN_NONE);
            if (grant_s != OWN_NONE) begin
                mem_we_r    <= issue_we_s;
                mem_addr_r  <= issue_addr_s;
                mem_wdata_r <= issue_wdata_s;
            end
            if (!vid_slot_s && both_elig_s) begin
                rr_owner_r <= (rr_owner_r == OWN_CPU) ? OWN_DMA : OWN_CPU;
            end
            // Busy drops after the ack cycle, so a held req re-arms one cycle later.
            if (grant_s == OWN_CPU) begin
                cpu_busy_r <= 1'b1;
            end else if (cpu_ack_r) begin
                cpu_busy_r <= 1'b0;
            end
            if (grant_s == OWN_DMA) begin
                dma_busy_r <= 1'b1;
            end else if (dma_ack_r) begin
                dma_busy_r <= 1'b0;
            end
        end
    end

    // Return stage: steer RAM read data to whichever requester owns the tail tag.
    always_ff @(posedge clk_sys or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            cpu_rdata_r <= {DW{1'b0}};
            dma_rdata_r <= {DW{1'b0}};
            vid_hold_r  <= {DW{1'b0}};
        end else begin
            cpu_ack_r <= (tail_s.owner == OWN_CPU);
            dma_ack_r <= (tail_s.owner == OWN_DMA);
            if (tail_s.owner == OWN_CPU && !tail_s.we) begin
                cpu_rdata_r <= mem_rdata;
            end
            if (tail_s.owner == OWN_DMA && !tail_s.we) begin
                dma_rdata_r <= mem_rdata;
            end
            if (tail_s.owner == OWN_VID) begin
                vid_hold_r <= mem_rdata;
            end
        end
    end

    // Video data is forwarded in its data-valid cycle so it lands before the next ce_pix.
    assign vid_valid = (tail_s.owner == OWN_VID);
    assign vid_rdata = vid_valid ? mem_rdata : vid_hold_r;

    assign cpu_ack   = cpu_ack_r;
    assign dma_ack   = dma_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dma_rdata = dma_rdata_r;
    assign cpu_wait  = cpu_req & ~cpu_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_pcw_mem_arbiter.sv
// Directed bench for pcw_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each backed by a small pipelined RAM model preloaded with mem[a] = a[7:0].
module tb_pcw_mem_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic ce_pix;
    logic reset_n_a, reset_n_b;

    logic          vid_req_a, vid_valid_a, cpu_req_a, cpu_we_a, cpu_ack_a, cpu_wait_a;
    logic          dma_req_a, dma_we_a, dma_ack_a, mem_en_a, mem_we_a;
    logic [AW-1:0] vid_addr_a, cpu_addr_a, dma_addr_a, mem_addr_a;
    logic [DW-1:0] vid_rdata_a, cpu_wdata_a, cpu_rdata_a, dma_wdata_a, dma_rdata_a;
    logic [DW-1:0] mem_wdata_a, mem_rdata_a;

    logic          vid_req_b, vid_valid_b, cpu_req_b, cpu_we_b, cpu_ack_b, cpu_wait_b;
    logic          dma_req_b, dma_we_b, dma_ack_b, mem_en_b, mem_we_b;
    logic [AW-1:0] vid_addr_b, cpu_addr_b, dma_addr_b, mem_addr_b;
    logic [DW-1:0] vid_rdata_b, cpu_wdata_b, cpu_rdata_b, dma_wdata_b, dma_rdata_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;

    pcw_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n_a), .ce_pix(ce_pix),
        .vid_req(vid_req_a), .vid_addr(vid_addr_a), .vid_rdata(vid_rdata_a), .vid_valid(vid_valid_a),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
        .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a), .cpu_wait(cpu_wait_a),
        .dma_req(dma_req_a), .dma_we(dma_we_a), .dma_addr(dma_addr_a), .dma_wdata(dma_wdata_a),
        .dma_rdata(dma_rdata_a), .dma_ack(dma_ack_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a)
    );

    pcw_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n_b), .ce_pix(ce_pix),
        .vid_req(vid_req_b), .vid_addr(vid_addr_b), .vid_rdata(vid_rdata_b), .vid_valid(vid_valid_b),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_wait(cpu_wait_b),
        .dma_req(dma_req_b), .dma_we(dma_we_b), .dma_addr(dma_addr_b), .dma_wdata(dma_wdata_b),
        .dma_rdata(dma_rdata_b), .dma_ack(dma_ack_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b)
    );

    // RAM models: read data appears MEM_LAT cycles after the mem_en cycle.
    logic [7:0] ram_a [0:(1<<17)-1];
    logic [7:0] ram_b [0:(1<<17)-1];
    logic [7:0] rd_a;
    logic [7:0] rd_b [3];

    always @(posedge clk_sys) begin
        if (mem_en_a) begin
            if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
            rd_a <= ram_a[mem_addr_a];
        end
    end

    always @(posedge clk_sys) begin
        rd_b[0] <= mem_en_b ? ram_b[mem_addr_b] : 8'h00;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b[2];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit ce_en   = 1'b0;
    bit ce_d1   = 1'b0;
    bit ce_d2   = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clk_sys cycle; ce_pix marks every 4th cycle when enabled.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        ce_d2  = ce_d1;
        ce_d1  = ce_pix;
        ce_pix = ce_en && (cyc % 4 == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      last_own;
        int      last_ack_cpu, last_ack_dma;
        int      own;
        int      n_en, n_early;
        logic [AW-1:0] b2b_addr [4];
        logic [7:0]    b2b_data [4];

        for (int i = 0; i < (1 << 17); i++) begin
            ram_a[i] = i[7:0];
            ram_b[i] = i[7:0];
        end
        rd_a = 8'h00;
        ce_pix = 1'b0;
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        {vid_req_a, cpu_req_a, cpu_we_a, dma_req_a, dma_we_a} = 5'b0;
        {vid_req_b, cpu_req_b, cpu_we_b, dma_req_b, dma_we_b} = 5'b0;
        vid_addr_a = 17'h0; cpu_addr_a = 17'h0; dma_addr_a = 17'h0;
        vid_addr_b = 17'h0; cpu_addr_b = 17'h0; dma_addr_b = 17'h0;
        cpu_wdata_a = 8'h0; dma_wdata_a = 8'h0; cpu_wdata_b = 8'h0; dma_wdata_b = 8'h0;

        // Reset state
        tick(); tick();
        chk_eq("rst_mem_en",    mem_en_a,    32'd0);
        chk_eq("rst_mem_we",    mem_we_a,    32'd0);
        chk_eq("rst_mem_addr",  mem_addr_a,  32'd0);
        chk_eq("rst_mem_wdata", mem_wdata_a, 32'd0);
        chk_eq("rst_vid_valid", vid_valid_a, 32'd0);
        chk_eq("rst_cpu_ack",   cpu_ack_a,   32'd0);
        chk_eq("rst_dma_ack",   dma_ack_a,   32'd0);
        chk_eq("rst_cpu_rdata", cpu_rdata_a, 32'd0);
        reset_n_a = 1'b1; reset_n_b = 1'b1;
        repeat (4) tick();

        // Video every ce_pix slot, MEM_LAT=1
        ce_en = 1'b1;
        vid_addr_a = 17'h12340;
        vid_req_a = 1'b1;
        repeat (12) begin
            tick();
            chk_eq("vid_mem_en", mem_en_a, 32'(ce_d1));
            if (ce_d1) begin
                chk_eq("vid_mem_addr", mem_addr_a, 32'h12340);
                chk_eq("vid_mem_we", mem_we_a, 32'd0);
            end
            chk_eq("vid_valid", vid_valid_a, 32'(ce_d2));
            if (ce_d2) chk_eq("vid_rdata", vid_rdata_a, 32'h40);
        end

        // vid_req outside ce_pix issues nothing
        ce_en = 1'b0; ce_pix = 1'b0;
        repeat (4) begin
            tick();
            chk_eq("vid_no_ce", mem_en_a, 32'd0);
        end
        vid_req_a = 1'b0;
        ce_en = 1'b1;
        tick();

        // Lone CPU read granted in an unused ce_pix slot
        for (int i = 0; i < 4 && !ce_pix; i++) tick();
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 17'h00100;
        #1;
        chk_eq("cpu1_wait0", cpu_wait_a, 32'd1);
        tick();
        chk_eq("cpu1_mem_en",   mem_en_a,   32'd1);
        chk_eq("cpu1_mem_addr", mem_addr_a, 32'h00100);
        chk_eq("cpu1_mem_we",   mem_we_a,   32'd0);
        chk_eq("cpu1_wait1",    cpu_wait_a, 32'd1);
        tick();
        chk_eq("cpu1_ack_early", cpu_ack_a,  32'd0);
        chk_eq("cpu1_wait2",     cpu_wait_a, 32'd1);
        tick();
        chk_eq("cpu1_ack",   cpu_ack_a,   32'd1);
        chk_eq("cpu1_rdata", cpu_rdata_a, 32'h00);
        chk_eq("cpu1_wait3", cpu_wait_a,  32'd0);
        cpu_req_a = 1'b0;
        tick();
        chk_eq("cpu1_ack_pulse", cpu_ack_a, 32'd0);

        // CPU + DMA continuous with video: alternating grants, bounded wait
        cpu_addr_a = 17'h00233; dma_addr_a = 17'h00355; dma_we_a = 1'b0;
        vid_req_a = 1'b1; cpu_req_a = 1'b1; dma_req_a = 1'b1;
        last_own = 0; last_ack_cpu = -1; last_ack_dma = -1;
        repeat (40) begin
            tick();
            if (ce_d1) begin
                chk_eq("rr_vid_slot_en",   mem_en_a,   32'd1);
                chk_eq("rr_vid_slot_addr", mem_addr_a, 32'h12340);
            end else if (mem_en_a) begin
                own = (mem_addr_a == 17'h00233) ? 1 : (mem_addr_a == 17'h00355) ? 2 : 3;
                chk_eq("rr_alternate", own, (last_own == 1) ? 2 : 1);
                if (own == 1 && last_ack_cpu >= 0)
                    chk_eq("rr_cpu_gap_ok", (cyc - 1 - last_ack_cpu) <= 4, 1);
                if (own == 2 && last_ack_dma >= 0)
                    chk_eq("rr_dma_gap_ok", (cyc - 1 - last_ack_dma) <= 4, 1);
                last_own = own;
            end
            if (cpu_ack_a) begin
                chk_eq("rr_cpu_rdata", cpu_rdata_a, 32'h33);
                last_ack_cpu = cyc;
            end
            if (dma_ack_a) begin
                chk_eq("rr_dma_rdata", dma_rdata_a, 32'h55);
                last_ack_dma = cyc;
            end
        end
        chk_eq("rr_saw_traffic", (last_ack_cpu > 0) && (last_ack_dma > 0), 1);
        cpu_req_a = 1'b0; dma_req_a = 1'b0; vid_req_a = 1'b0;
        repeat (8) tick();

        // DMA write 0x1FFFF <= 0xA5, then CPU reads it back
        dma_req_a = 1'b1; dma_we_a = 1'b1; dma_addr_a = 17'h1FFFF; dma_wdata_a = 8'hA5;
        tick();
        chk_eq("wr_mem_en",    mem_en_a,    32'd1);
        chk_eq("wr_mem_we",    mem_we_a,    32'd1);
        chk_eq("wr_mem_addr",  mem_addr_a,  32'h1FFFF);
        chk_eq("wr_mem_wdata", mem_wdata_a, 32'hA5);
        tick(); tick();
        chk_eq("wr_dma_ack",   dma_ack_a,   32'd1);
        chk_eq("wr_dma_rdata", dma_rdata_a, 32'h55);
        dma_req_a = 1'b0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 17'h1FFFF;
        tick(); tick(); tick();
        chk_eq("rd_cpu_ack",   cpu_ack_a,   32'd1);
        chk_eq("rd_cpu_rdata", cpu_rdata_a, 32'hA5);
        cpu_req_a = 1'b0;
        tick();

        // MEM_LAT=3: reset one cycle after a CPU grant discards the op
        cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 17'h00077;
        tick();
        chk_eq("l3_grant_en", mem_en_b, 32'd1);
        reset_n_b = 1'b0; cpu_req_b = 1'b0;
        #1;
        chk_eq("l3_rst_mem_en",    mem_en_b,    32'd0);
        chk_eq("l3_rst_mem_addr",  mem_addr_b,  32'd0);
        chk_eq("l3_rst_mem_we",    mem_we_b,    32'd0);
        chk_eq("l3_rst_mem_wdata", mem_wdata_b, 32'd0);
        chk_eq("l3_rst_cpu_ack",   cpu_ack_b,   32'd0);
        chk_eq("l3_rst_dma_ack",   dma_ack_b,   32'd0);
        chk_eq("l3_rst_vid_valid", vid_valid_b, 32'd0);
        chk_eq("l3_rst_rdata",     {cpu_rdata_b, dma_rdata_b, vid_rdata_b}, 32'd0);
        tick(); tick();
        reset_n_b = 1'b1;
        repeat (10) begin
            tick();
            chk_eq("l3_no_stale_ack", cpu_ack_b, 32'd0);
        end
        cpu_req_b = 1'b1; cpu_addr_b = 17'h00088;
        #1;
        chk_eq("l3_new_wait", cpu_wait_b, 32'd1);
        n_early = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i < 5) n_early += int'(cpu_ack_b);
        end
        chk_eq("l3_new_early_ack", n_early,     32'd0);
        chk_eq("l3_new_ack",       cpu_ack_b,   32'd1);
        chk_eq("l3_new_rdata",     cpu_rdata_b, 32'h88);
        cpu_req_b = 1'b0;
        repeat (3) tick();

        // MEM_LAT=3 back-to-back CPU reads: one op in flight, data per address
        b2b_addr[0] = 17'h00011; b2b_data[0] = 8'h11;
        b2b_addr[1] = 17'h10022; b2b_data[1] = 8'h22;
        b2b_addr[2] = 17'h00133; b2b_data[2] = 8'h33;
        b2b_addr[3] = 17'h1FF44; b2b_data[3] = 8'h44;
        cpu_req_b = 1'b1; cpu_addr_b = b2b_addr[0];
        for (int k = 0; k < 4; k++) begin
            n_en = 0; n_early = 0;
            for (int i = 1; i <= ((k == 0) ? 5 : 6); i++) begin
                tick();
                n_en += int'(mem_en_b);
                if (i < ((k == 0) ? 5 : 6)) n_early += int'(cpu_ack_b);
            end
            chk_eq("b2b_one_in_flight", n_en,        32'd1);
            chk_eq("b2b_early_ack",     n_early,     32'd0);
            chk_eq("b2b_ack",           cpu_ack_b,   32'd1);
            chk_eq("b2b_rdata",         cpu_rdata_b, 32'(b2b_data[k]));
            if (k < 3) cpu_addr_b = b2b_addr[k+1];
        end
        cpu_req_b = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pcw_mem_arbiter.md
Name: pcw_mem_arbiter

Overview:
- Shares the single-port 17-bit-address, 8-bit-data video/system RAM between three requesters: video fetch (roller-RAM lookup and pixel fetch), Z80 CPU and disk DMA.
- Video owns every ce_pix cycle. The other clk_sys cycles, and any ce_pix cycle video leaves unused, go to CPU and DMA in round-robin order.
- Sits between the video controller / CPU bus logic and the RAM macro. The RAM is pipelined, accepts one operation per cycle and has a fixed read latency.

Parameters:
- AW, 17, address width.
- DW, 8, data width.
- MEM_LAT, 1, clk_sys cycles from mem_en to mem_rdata valid (1..4).

Ports:
- clk_sys  in  1  system clock (64 MHz)
- reset_n  in  1  asynchronous, active-low reset
- ce_pix  in  1  pixel strobe, 1 clk_sys cycle in 4; marks the video slot
- vid_req  in  1  video wants a read this ce_pix slot
- vid_addr  in  AW  video read address
- vid_rdata  out  DW  video read data, held until the next video return
- vid_valid  out  1  one-cycle pulse: vid_rdata updated
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack, then held
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  cpu_req & ~cpu_ack, used to stall the Z80
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same widths and rules as the cpu_* ports
- mem_en  out  1  RAM operation strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, MEM_LAT cycles after mem_en

Behaviour:
- Reset (async assert, sync release): mem_en, mem_we, vid_valid, cpu_ack, dma_ack = 0. mem_addr, mem_wdata, all rdata outputs = 0. Tag pipeline = NONE. Round-robin pointer = CPU. Busy flags cleared.
- Reset mid-operation discards in-flight ops: no ack and no vid_valid is produced for them after release.
- Issue stage is combinational from the requests, then registered onto the mem_* outputs. An op issued at cycle t drives mem_* at t+1.
- Slot decision each clk_sys cycle:
  - ce_pix=1 and vid_req=1: issue video read. Video is never refused and never delayed.
  - Otherwise (free slot): choose among eligible CPU/DMA. Eligible means req=1 and not busy.
    - Both eligible: grant the round-robin pointer's owner, then flip the pointer to the other.
    - One eligible: grant it; the pointer is unchanged.
    - None eligible: mem_en=0, and mem_addr/mem_we/mem_wdata hold their previous values.
- Busy flag: set on grant, cleared on that requester's ack. A requester has at most one op in flight.
- Tag pipeline: MEM_LAT+1 stages of owner_t, aligned so the tag reaches the output stage in the cycle mem_rdata is valid. The output stage then:
  - VID: vid_rdata <= mem_rdata, vid_valid=1.
  - CPU read: cpu_rdata <= mem_rdata, cpu_ack=1.
  - CPU write: cpu_ack=1, cpu_rdata unchanged.
  - DMA: same as CPU on the dma_* ports.
- Latency, request to ack, for CPU/DMA = MEM_LAT+2 cycles when granted immediately. Video return is MEM_LAT+1 cycles after the ce_pix cycle, i.e. before the next ce_pix when MEM_LAT<=2.
- A requester holding req high in the cycle after its ack starts a new request. Eligibility re-evaluates that cycle.
- Worst-case CPU wait with continuous video and DMA traffic: 3 free slots per 4 cycles, alternating, so CPU is granted within 4 cycles of becoming eligible.
- Address and write data are sampled only in the grant cycle. Changes while busy are ignored.
- vid_req=1 on a non-ce_pix cycle is ignored; no video op issues.
- No address decoding and no wrap handling: addresses pass through unchanged, full AW bits.

Decomposition:
- Package pcw_mem_pkg holds:
  - owner_t enum {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA}
  - localparams PCW_AW=17, PCW_DW=8
  - a per-entry struct {owner_t owner; logic we;}
- Sub-module mem_tag_pipe: parameterised-depth shift register of that struct with async active-low clear. Instantiated once.

Test Plan:
- Reset with MEM_LAT=1. Apply vid_req every ce_pix, vid_addr=0x1_2340, mem model returns addr[7:0] -> mem_en high exactly on the cycle after each ce_pix, vid_valid pulses 2 cycles after ce_pix with vid_rdata=0x40, and no CPU/DMA op ever occupies that slot.
- CPU read 0x0_0100 alone, vid_req=0 -> granted in the next cycle even if it is a ce_pix slot, cpu_ack 3 cycles after req with cpu_rdata=0x00, cpu_wait high for exactly 3 cycles.
- CPU and DMA both request continuously with video active -> grants alternate CPU,DMA,CPU,... across the free slots, and no requester waits more than 4 cycles between ack and its next grant.
- DMA write 0x1_FFFF<=0xA5 then CPU read 0x1_FFFF -> mem_we=1 with mem_addr=0x1_FFFF and mem_wdata=0xA5, then the CPU receives 0xA5, and dma_rdata is unchanged by the write.
- Assert reset_n=0 one cycle after a CPU grant (MEM_LAT=3) -> all outputs 0 asynchronously, and no cpu_ack ever appears after release. A new request after release completes normally.
- MEM_LAT=3 with back-to-back CPU requests -> exactly one CPU op in flight at a time, and each cpu_ack matches its own address's data.
